// File: rtl/shift_sub_divider_pkg.sv
// Shared constants for the arithmetic unit's sequential machines (divider and
// shift-add multiplier control both use these state values).
package shift_sub_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 6;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_CALC = 2'd1,
    STATE_DONE = 2'd2
  } stateT;

endpackage

// File: rtl/shift_sub_divider_div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract D,
// keep the difference when it does not borrow.
module div_step
  import shift_sub_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   remIn,
  input  logic [WIDTH-1:0] quoIn,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   remOut,
  output logic [WIDTH-1:0] quoOut,
  output logic             quoBit
);

  logic [WIDTH+1:0] remShift;
  logic [WIDTH+1:0] trial;

  // One spare top bit so the borrow is unambiguous for any R input.
  assign remShift = {remIn, quoIn[WIDTH-1]};
  assign trial    = remShift - {2'b00, divisor};
  assign quoBit   = ~trial[WIDTH+1];
  assign remOut   = quoBit ? trial[WIDTH:0] : remShift[WIDTH:0];
  assign quoOut   = {quoIn[WIDTH-2:0], quoBit};

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// request/acknowledge handshake shared with the shift-add multiplier.
module shift_sub_divider
  import shift_sub_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iValid_Data,
  input  logic [WIDTH-1:0] iDividend,
  input  logic [WIDTH-1:0] iDivisor,
  input  logic             iAck,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oQuotient,
  output logic [WIDTH-1:0] oRemainder,
  output logic             oDivByZero
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  stateT            stateReg;
  logic [WIDTH:0]   remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] divReg;
  logic [CNT_W-1:0] cntReg;

  logic [WIDTH:0]   stepRem;
  logic [WIDTH-1:0] stepQuo;
  logic             stepBit;

  div_step #(.WIDTH(WIDTH)) uDivStep (
    .remIn   (remReg),
    .quoIn   (quoReg),
    .divisor (divReg),
    .remOut  (stepRem),
    .quoOut  (stepQuo),
    .quoBit  (stepBit)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stateReg   <= STATE_IDLE;
      remReg     <= '0;
      quoReg     <= '0;
      divReg     <= '0;
      cntReg     <= '0;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      oQuotient  <= '0;
      oRemainder <= '0;
      oDivByZero <= 1'b0;
    end else begin
      case (stateReg)
        STATE_IDLE: begin
          if (iValid_Data) begin
            quoReg <= iDividend;
            divReg <= iDivisor;
            remReg <= '0;
            cntReg <= '0;
            // A zero divisor skips iteration and reports saturated quotient.
            if (iDivisor == '0) begin
              stateReg   <= STATE_DONE;
              oDone      <= 1'b1;
              oDivByZero <= 1'b1;
              oQuotient  <= '1;
              oRemainder <= iDividend;
            end else begin
              stateReg <= STATE_CALC;
              oBusy    <= 1'b1;
            end
          end
        end
        STATE_CALC: begin
          remReg <= stepRem;
          quoReg <= stepQuo;
          cntReg <= cntReg + CNT_W'(1);
          if (cntReg == LAST_ITER) begin
            stateReg   <= STATE_DONE;
            oBusy      <= 1'b0;
            oDone      <= 1'b1;
            oQuotient  <= {quoReg[WIDTH-2:0], stepBit};
            oRemainder <= stepRem[WIDTH-1:0];
          end
        end
        STATE_DONE: begin
          if (iAck) begin
            stateReg   <= STATE_IDLE;
            oDone      <= 1'b0;
            oDivByZero <= 1'b0;
          end
        end
        default: begin
          stateReg   <= STATE_IDLE;
          oBusy      <= 1'b0;
          oDone      <= 1'b0;
          oDivByZero <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Scoreboard bench for shift_sub_divider: driver pushes reference results,
// a negedge monitor pops and compares whenever oDone rises.
module tb_shift_sub_divider;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  logic             Clock = 1'b0;
  logic             Reset = 1'b0;
  logic             iValid_Data = 1'b0;
  logic [WIDTH-1:0] iDividend = '0;
  logic [WIDTH-1:0] iDivisor = '0;
  logic             iAck = 1'b0;
  logic             oBusy;
  logic             oDone;
  logic [WIDTH-1:0] oQuotient;
  logic [WIDTH-1:0] oRemainder;
  logic             oDivByZero;

  shift_sub_divider #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .iValid_Data(iValid_Data),
    .iDividend  (iDividend),
    .iDivisor   (iDivisor),
    .iAck       (iAck),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oQuotient  (oQuotient),
    .oRemainder (oRemainder),
    .oDivByZero (oDivByZero)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             dbz;
    longint           latency;
    int               busyCycles;
    longint           acceptCycle;
  } expT;

  expT    expQ[$];
  int     vectors = 0;
  int     miscompares = 0;
  longint cycleCount = 0;

  always @(posedge Clock) cycleCount <= cycleCount + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleCount);
    end
  endtask

  // Reference behaviour from plain integer division.
  function automatic expT model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    expT e;
    e.dividend = a;
    e.divisor  = b;
    if (b == 0) begin
      e.quo = {WIDTH{1'b1}}; e.rem = a; e.dbz = 1'b1;
      e.latency = 0; e.busyCycles = 0;
    end else begin
      e.quo = a / b; e.rem = a % b; e.dbz = 1'b0;
      e.latency = WIDTH; e.busyCycles = WIDTH;
    end
    e.acceptCycle = 0;
    return e;
  endfunction

  // Monitor
  initial begin
    int busyCnt = 0;
    logic prevDone = 1'b0;
    logic [WIDTH-1:0] holdQ = '0, holdR = '0;
    logic holdZ = 1'b0;
    expT e;
    logic [63:0] recon;
    forever begin
      @(negedge Clock);
      if (!Reset) begin
        busyCnt = 0;
        prevDone = 1'b0;
      end else begin
        if (oBusy) busyCnt++;
        if (oDone && !prevDone) begin
          if (expQ.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_done: got oDone=1, expected no result pending (cycle %0d)", cycleCount);
          end else begin
            e = expQ.pop_front();
            check("quotient", oQuotient, e.quo);
            check("remainder", oRemainder, e.rem);
            check("div_by_zero", oDivByZero, e.dbz);
            check("latency", cycleCount - e.acceptCycle, e.latency);
            check("busy_cycles", busyCnt, e.busyCycles);
            if (e.divisor != 0) begin
              recon = 64'(oQuotient) * 64'(e.divisor) + 64'(oRemainder);
              check("invariant", recon, 64'(e.dividend));
              check("rem_lt_div", oRemainder < e.divisor, 1'b1);
            end
            $display("div %0d / %0d -> q=%0d r=%0d dbz=%0b", e.dividend, e.divisor,
                     oQuotient, oRemainder, oDivByZero);
          end
          holdQ = oQuotient; holdR = oRemainder; holdZ = oDivByZero;
          busyCnt = 0;
        end else if (oDone && prevDone) begin
          check("hold_quotient", oQuotient, holdQ);
          check("hold_remainder", oRemainder, holdR);
          check("hold_dbz", oDivByZero, holdZ);
        end
        prevDone = oDone;
      end
    end
  end

  task automatic startReq(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    expT e;
    int n;
    @(negedge Clock);
    n = 0;
    while ((oBusy || oDone) && n < 200) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 200) begin
      vectors++; miscompares++;
      $display("FAIL idle_timeout: got busy/done stuck, expected IDLE within 200 cycles");
    end
    iValid_Data = 1'b1; iDividend = a; iDivisor = b;
    e = model(a, b);
    e.acceptCycle = cycleCount + 1;
    expQ.push_back(e);
    @(posedge Clock); #1;
    iValid_Data = 1'b0; iDividend = $urandom; iDivisor = $urandom;
  endtask

  task automatic waitDone(input bit noise);
    int n = 0;
    while (!oDone && n < 100) begin
      @(negedge Clock);
      if (noise) begin
        iValid_Data = 1'($urandom % 2); iDividend = $urandom; iDivisor = $urandom;
      end
      n++;
    end
    iValid_Data = 1'b0;
    if (!oDone) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout: got oDone=0, expected oDone within 100 cycles");
      expQ.delete();
    end
  endtask

  task automatic ackResult(input int delay);
    repeat (delay) begin
      @(negedge Clock);
      check("done_held", oDone, 1'b1);
    end
    @(negedge Clock);
    iAck = 1'b1;
    @(negedge Clock);
    iAck = 1'b0;
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input int ackDelay, input bit noise);
    startReq(a, b);
    waitDone(noise);
    ackResult(ackDelay);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, expected completion before 5 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    expT e;
    logic [WIDTH-1:0] a, b;

    repeat (3) @(negedge Clock);
    check("reset_busy", oBusy, 1'b0);
    check("reset_done", oDone, 1'b0);
    check("reset_quotient", oQuotient, '0);
    check("reset_remainder", oRemainder, '0);
    check("reset_dbz", oDivByZero, 1'b0);
    Reset = 1'b1;

    issue(32'd100, 32'd7, 10, 1'b0);
    issue(32'd5, 32'd9, 0, 1'b0);
    issue(32'd0, 32'd3, 1, 1'b0);
    issue(32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    issue(32'd1234, 32'd0, 2, 1'b0);

    // Ack and a new request together: ack wins, request waits an edge.
    startReq(32'd200, 32'd9);
    waitDone(1'b0);
    @(negedge Clock);
    iAck = 1'b1; iValid_Data = 1'b1; iDividend = 32'd77; iDivisor = 32'd5;
    @(posedge Clock); #1;
    check("ackval_done_clear", oDone, 1'b0);
    check("ackval_not_accepted", oBusy, 1'b0);
    iAck = 1'b0;
    e = model(32'd77, 32'd5);
    e.acceptCycle = cycleCount + 1;
    expQ.push_back(e);
    @(posedge Clock); #1;
    check("ackval_accepted", oBusy, 1'b1);
    iValid_Data = 1'b0;
    waitDone(1'b0);
    ackResult(0);

    // Asynchronous reset in the middle of an iteration.
    startReq(32'd1000, 32'd3);
    repeat (15) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    check("midreset_busy", oBusy, 1'b0);
    check("midreset_done", oDone, 1'b0);
    check("midreset_quotient", oQuotient, '0);
    check("midreset_remainder", oRemainder, '0);
    check("midreset_dbz", oDivByZero, 1'b0);
    expQ.delete();
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    issue(32'd1000, 32'd3, 0, 1'b0);

    for (int i = 0; i < 1200; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom_range(1, 255);
        1: b = $urandom;
        2: b = a + $urandom_range(1, 100);
        default: b = ($urandom >> $urandom_range(0, 31)) | 32'd1;
      endcase
      issue(a, b, $urandom_range(0, 3), 1'($urandom % 2));
    end

    repeat (5) @(negedge Clock);
    check("queue_drained", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
